// File: rtl/riscv_core_mul_ctrl.sv
// M-extension multiply sequencer: accepts one request, launches operand magnitudes into a
// fixed-latency unsigned multiplier, captures the sign-corrected result and holds it for writeback.
`timescale 1ns/1ps

module riscv_core_mul_ctrl #(
    parameter int XLEN    = 64,
    parameter int MUL_LAT = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_mul_valid,
    output logic                o_mul_ready,
    input  logic [XLEN-1:0]     i_mul_srcA,
    input  logic [XLEN-1:0]     i_mul_srcB,
    input  logic [1:0]          i_mul_control,
    input  logic                i_mul_isword,
    input  logic                i_flush,
    output logic                o_mult_start,
    output logic [XLEN-1:0]     o_mult_opA,
    output logic [XLEN-1:0]     o_mult_opB,
    input  logic [2*XLEN-1:0]   i_mult_product,
    output logic [XLEN-1:0]     o_out_srcA,
    output logic [XLEN-1:0]     o_out_srcB,
    output logic [1:0]          o_out_control,
    output logic                o_out_isword,
    output logic [2*XLEN-1:0]   o_out_product,
    input  logic [XLEN-1:0]     i_out_result,
    output logic                o_result_valid,
    input  logic                i_result_ready,
    output logic [XLEN-1:0]     o_result
);

    localparam int CW = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);
    localparam logic [CW-1:0] LAT_LD  = CW'(MUL_LAT);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_mult_start;
    logic [XLEN-1:0]        r_mult_opA;
    logic [XLEN-1:0]        r_mult_opB;
    logic [XLEN-1:0]        r_out_srcA;
    logic [XLEN-1:0]        r_out_srcB;
    logic [1:0]             r_out_control;
    logic                   r_out_isword;
    logic                   r_result_valid;
    logic [XLEN-1:0]        r_result;

    logic                   w_ready;
    logic                   w_accept;
    logic [XLEN-1:0]        w_magA;
    logic [XLEN-1:0]        w_magB;

    function automatic logic [XLEN-1:0] f_abs_x(input logic [XLEN-1:0] x);
        f_abs_x = x[XLEN-1] ? (~x + {{(XLEN-1){1'b0}}, 1'b1}) : x;
    endfunction

    function automatic logic [XLEN-1:0] f_abs_w(input logic [31:0] x);
        logic [31:0] m;
        m = x[31] ? (~x + 32'd1) : x;
        f_abs_w = {{(XLEN-32){1'b0}}, m};
    endfunction

    assign w_ready  = (r_state == S_IDLE) & ~i_flush;
    assign w_accept = w_ready & i_mul_valid;

    // Operand magnitudes: word ops take sign from bit 31, MULHSU/MULHU leave unsigned sources raw
    always_comb begin
        w_magA = i_mul_srcA;
        w_magB = i_mul_srcB;
        if (i_mul_isword) begin
            w_magA = f_abs_w(i_mul_srcA[31:0]);
            w_magB = f_abs_w(i_mul_srcB[31:0]);
        end else begin
            case (i_mul_control)
                2'b00, 2'b01: begin
                    w_magA = f_abs_x(i_mul_srcA);
                    w_magB = f_abs_x(i_mul_srcB);
                end
                2'b10: begin
                    w_magA = f_abs_x(i_mul_srcA);
                    w_magB = i_mul_srcB;
                end
                2'b11: begin
                    w_magA = i_mul_srcA;
                    w_magB = i_mul_srcB;
                end
                default: begin
                    w_magA = i_mul_srcA;
                    w_magB = i_mul_srcB;
                end
            endcase
        end
    end

    // Sequencer FSM with all outputs registered; the launch cycle holds the counter so the
    // result is captured MUL_LAT+2 edges after acceptance, one cycle into the product window
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= CNT_ZERO;
            r_mult_start   <= 1'b0;
            r_mult_opA     <= {XLEN{1'b0}};
            r_mult_opB     <= {XLEN{1'b0}};
            r_out_srcA     <= {XLEN{1'b0}};
            r_out_srcB     <= {XLEN{1'b0}};
            r_out_control  <= 2'b00;
            r_out_isword   <= 1'b0;
            r_result_valid <= 1'b0;
            r_result       <= {XLEN{1'b0}};
        end else begin
            r_mult_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_out_srcA    <= i_mul_srcA;
                        r_out_srcB    <= i_mul_srcB;
                        r_out_control <= i_mul_control;
                        r_out_isword  <= i_mul_isword;
                        r_mult_opA    <= w_magA;
                        r_mult_opB    <= w_magB;
                        r_cnt         <= LAT_LD;
                        r_mult_start  <= 1'b1;
                        r_state       <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (i_flush) begin
                        r_state <= S_IDLE;
                        r_cnt   <= CNT_ZERO;
                    end else if (r_mult_start) begin
                        r_cnt <= r_cnt;
                    end else if (r_cnt == CNT_ZERO) begin
                        r_result       <= i_out_result;
                        r_result_valid <= 1'b1;
                        r_state        <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_DONE: begin
                    if (i_flush || i_result_ready) begin
                        r_state        <= S_IDLE;
                        r_result_valid <= 1'b0;
                        r_cnt          <= CNT_ZERO;
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_result_valid <= 1'b0;
                    r_cnt          <= CNT_ZERO;
                end
            endcase
        end
    end

    assign o_mul_ready    = w_ready;
    assign o_mult_start   = r_mult_start;
    assign o_mult_opA     = r_mult_opA;
    assign o_mult_opB     = r_mult_opB;
    assign o_out_srcA     = r_out_srcA;
    assign o_out_srcB     = r_out_srcB;
    assign o_out_control  = r_out_control;
    assign o_out_isword   = r_out_isword;
    assign o_out_product  = i_mult_product;
    assign o_result_valid = r_result_valid;
    assign o_result       = r_result;

    riscv_core_mul_ctrl_chk u_chk (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_accept     (w_accept),
        .i_mult_start (r_mult_start)
    );

endmodule

// Property checker: the launch pulse only follows an accept edge.
module riscv_core_mul_ctrl_chk (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_accept,
    input  logic i_mult_start
);

    a_start_first_busy: assert property (@(posedge i_clk) disable iff (i_rst)
        i_mult_start |-> $past(i_accept));

endmodule

// File: tb/tb_riscv_core_mul_ctrl.sv
// Scoreboard bench for riscv_core_mul_ctrl with an ideal multiplier and a sign-correction model.
`timescale 1ns/1ps

module tb_riscv_core_mul_ctrl;

    localparam int XLEN    = 64;
    localparam int MUL_LAT = 4;

    logic                i_clk = 1'b0;
    logic                i_rst = 1'b1;
    logic                i_mul_valid = 1'b0;
    logic                o_mul_ready;
    logic [XLEN-1:0]     i_mul_srcA = '0;
    logic [XLEN-1:0]     i_mul_srcB = '0;
    logic [1:0]          i_mul_control = 2'b00;
    logic                i_mul_isword = 1'b0;
    logic                i_flush = 1'b0;
    logic                o_mult_start;
    logic [XLEN-1:0]     o_mult_opA;
    logic [XLEN-1:0]     o_mult_opB;
    logic [2*XLEN-1:0]   i_mult_product = '0;
    logic [XLEN-1:0]     o_out_srcA;
    logic [XLEN-1:0]     o_out_srcB;
    logic [1:0]          o_out_control;
    logic                o_out_isword;
    logic [2*XLEN-1:0]   o_out_product;
    logic [XLEN-1:0]     i_out_result;
    logic                o_result_valid;
    logic                i_result_ready = 1'b1;
    logic [XLEN-1:0]     o_result;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];

    riscv_core_mul_ctrl #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_mul_valid(i_mul_valid), .o_mul_ready(o_mul_ready),
        .i_mul_srcA(i_mul_srcA), .i_mul_srcB(i_mul_srcB),
        .i_mul_control(i_mul_control), .i_mul_isword(i_mul_isword),
        .i_flush(i_flush),
        .o_mult_start(o_mult_start), .o_mult_opA(o_mult_opA), .o_mult_opB(o_mult_opB),
        .i_mult_product(i_mult_product),
        .o_out_srcA(o_out_srcA), .o_out_srcB(o_out_srcB),
        .o_out_control(o_out_control), .o_out_isword(o_out_isword),
        .o_out_product(o_out_product), .i_out_result(i_out_result),
        .o_result_valid(o_result_valid), .i_result_ready(i_result_ready),
        .o_result(o_result)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact result of the RISC-V multiply from signed/unsigned extended arithmetic
    function automatic logic [63:0] ref_res(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] c, input logic w);
        logic [127:0] ea, eb, pr;
        if (w) begin
            ea = {{96{a[31]}}, a[31:0]};
            eb = {{96{b[31]}}, b[31:0]};
            pr = ea * eb;
            return {{32{pr[31]}}, pr[31:0]};
        end
        ea = (c == 2'b11) ? {64'd0, a} : {{64{a[63]}}, a};
        eb = c[1] ? {64'd0, b} : {{64{b[63]}}, b};
        pr = ea * eb;
        return (c == 2'b00) ? pr[63:0] : pr[127:64];
    endfunction

    function automatic logic [63:0] ref_mag(input logic [63:0] x, input logic sgn, input logic w);
        logic [63:0] v;
        v = w ? {{32{x[31]}}, x[31:0]} : x;
        if (sgn && v[63]) return 64'd0 - v;
        return v;
    endfunction

    // Ideal unsigned multiplier: product shows up MUL_LAT cycles after the launch, valid for one cycle
    int m_cnt = 0;
    logic [127:0] m_pend = '0;
    always @(posedge i_clk) begin
        if (o_mult_start) begin
            m_pend = {64'd0, o_mult_opA} * {64'd0, o_mult_opB};
            m_cnt  = MUL_LAT;
            i_mult_product <= {$urandom, $urandom, $urandom, $urandom};
        end else if (m_cnt > 1) begin
            m_cnt = m_cnt - 1;
            i_mult_product <= {$urandom, $urandom, $urandom, $urandom};
        end else if (m_cnt == 1) begin
            m_cnt = 0;
            i_mult_product <= m_pend;
        end else begin
            i_mult_product <= {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // Sign-correction stage model fed from the captured raw operands
    always_comb begin
        logic neg;
        logic [127:0] p;
        neg = 1'b0;
        if (o_out_isword) neg = o_out_srcA[31] ^ o_out_srcB[31];
        else if (!o_out_control[1]) neg = o_out_srcA[63] ^ o_out_srcB[63];
        else if (o_out_control == 2'b10) neg = o_out_srcA[63];
        p = neg ? (128'd0 - o_out_product) : o_out_product;
        if (o_out_isword) i_out_result = {{32{p[31]}}, p[31:0]};
        else if (o_out_control == 2'b00) i_out_result = p[63:0];
        else i_out_result = p[127:64];
    end

    // Monitor: every handoff pops one expectation
    always begin
        @(negedge i_clk);
        #2;
        if (!i_rst && o_result_valid && i_result_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", o_result_valid, 1'b0);
            else chk("result", o_result, exp_q.pop_front());
        end
    end

    task automatic chk_zero(input string name);
        chk(name, |{o_mult_start, o_result_valid, o_result, o_mult_opA, o_mult_opB,
                    o_out_srcA, o_out_srcB, o_out_control, o_out_isword}, 1'b0);
        chk({name, "_idle"}, o_mul_ready, 1'b1);
    endtask

    // mode: 0 normal, 1 flush at T+3, 2 reset at T+2, 3 reset in DONE
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] c,
                          input logic w, input int mode, input int bp, output int waited);
        int k;
        logic ok;
        logic [63:0] held;
        logic sa, sb;
        waited = 0;
        while (!o_mul_ready && waited < 50) begin
            @(negedge i_clk);
            waited++;
        end
        if (waited >= 50) begin
            chk("ready_timeout", o_mul_ready, 1'b1);
            return;
        end
        i_mul_srcA = a; i_mul_srcB = b; i_mul_control = c; i_mul_isword = w;
        i_mul_valid = 1'b1;
        i_result_ready = (bp == 0 && mode != 3);
        if (mode == 0) exp_q.push_back(ref_res(a, b, c, w));
        @(negedge i_clk);
        i_mul_valid = 1'b0;
        i_mul_srcA = {$urandom, $urandom};
        i_mul_srcB = {$urandom, $urandom};
        sa = w || (c != 2'b11);
        sb = w || !c[1];
        chk("start_pulse", o_mult_start, 1'b1);
        chk("opA", o_mult_opA, ref_mag(a, sa, w));
        chk("opB", o_mult_opB, ref_mag(b, sb, w));
        chk("captured", {o_out_srcA, o_out_srcB, o_out_control, o_out_isword}, {a, b, c, w});
        if (mode == 1) begin
            repeat (2) @(negedge i_clk);
            i_flush = 1'b1;
            #1 chk("flush_blocks_ready", o_mul_ready, 1'b0);
            @(negedge i_clk);
            i_flush = 1'b0;
            #1 chk("flush_idle", o_mul_ready, 1'b1);
            ok = 1'b1;
            repeat (10) begin
                @(negedge i_clk);
                if (o_result_valid) ok = 1'b0;
            end
            chk("flush_no_valid", ok, 1'b1);
            return;
        end
        if (mode == 2) begin
            @(negedge i_clk);
            i_rst = 1'b1;
            @(negedge i_clk);
            chk_zero("rst_busy");
            i_rst = 1'b0;
            return;
        end
        k = 0;
        while (!o_result_valid && k < 20) begin
            @(negedge i_clk);
            k++;
            if (k == 1) chk("start_one_cycle", o_mult_start, 1'b0);
        end
        chk("latency", k, MUL_LAT + 2);
        if (mode == 3) begin
            i_rst = 1'b1;
            @(negedge i_clk);
            chk_zero("rst_done");
            i_rst = 1'b0;
            i_result_ready = 1'b1;
            return;
        end
        if (bp > 0) begin
            held = o_result;
            ok = 1'b1;
            i_mul_valid = 1'b1;
            repeat (bp) begin
                @(negedge i_clk);
                if (o_result !== held || !o_result_valid || o_mul_ready || o_mult_start) ok = 1'b0;
            end
            chk("backpressure_hold", ok, 1'b1);
            i_mul_valid = 1'b0;
            i_result_ready = 1'b1;
        end
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0: return 64'h8000_0000_0000_0000;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h0;
            3: return {$urandom, 32'h8000_0000};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int wt;
        logic [1:0] c;
        logic w;
        repeat (3) @(negedge i_clk);
        chk_zero("reset_state");
        i_rst = 1'b0;
        @(negedge i_clk);

        run_op(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 2'b00, 1'b0, 0, 0, wt);
        run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 1'b0, 0, 0, wt);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0, 0, 0, wt);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, 0, 0, wt);
        run_op(64'h1234_5678_8000_0000, 64'd2, 2'b00, 1'b1, 0, 0, wt);
        run_op(64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 2'b00, 1'b1, 0, 0, wt);
        run_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 2'b01, 1'b0, 0, 10, wt);
        run_op(64'd11, 64'd13, 2'b00, 1'b0, 0, 0, wt);
        chk("accept_after_handoff", wt, 1);
        run_op(64'd100, 64'd200, 2'b00, 1'b0, 1, 0, wt);
        run_op(64'hFFFF_FFFF_FFFF_FFF0, 64'd3, 2'b00, 1'b0, 0, 0, wt);
        run_op(64'd9, 64'd9, 2'b00, 1'b0, 2, 0, wt);
        run_op(64'd21, 64'd2, 2'b00, 1'b0, 0, 0, wt);
        run_op(64'd5, 64'd6, 2'b00, 1'b0, 3, 0, wt);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'b10, 1'b0, 0, 0, wt);

        for (int i = 0; i < 30; i++) begin
            c = 2'($urandom_range(0, 3));
            w = ($urandom_range(0, 3) == 0);
            if (w) c = 2'b00;
            run_op(pick(), pick(), c, w, 0, $urandom_range(0, 2), wt);
        end

        repeat (5) @(negedge i_clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
